// File: rtl/u_mem_bram_slave.sv
// Avalon-MM burst responder over an on-chip word memory with byte enables.
// Define U_MEM_SLAVE_ERR_CNT_EN to enable the saturating protocol-error counter.
module u_mem_bram_slave #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 512,
    parameter int BURST_WIDTH  = 7,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [BURST_WIDTH-1:0]  burstcount,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic [15:0]             err_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BEW   = DATA_WIDTH / 8;
    localparam int L     = READ_LATENCY;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BURST_WIDTH-1:0]  rem_q, rem_d;
    logic                    waitrequest_q;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic                    rd_issue;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [L-1:0]            pv_q;
    logic [DATA_WIDTH-1:0]   pd_q [L];
    logic [L-1:0]            sv;
    logic [DATA_WIDTH-1:0]   sd [L];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        rd_issue  = 1'b0;
        rd_addr   = addr_q;
        unique case (state_q)
            IDLE: begin
                if (!waitrequest_q && burstcount != '0) begin
                    if (write) begin
                        mem_we    = 1'b1;
                        mem_waddr = address;
                        if (burstcount > BURST_WIDTH'(1)) begin
                            state_d = WR_BURST;
                            rem_d   = burstcount - BURST_WIDTH'(1);
                            addr_d  = address + ADDR_WIDTH'(1);
                        end
                    end else if (read) begin
                        rd_issue = 1'b1;
                        rd_addr  = address;
                        if (burstcount > BURST_WIDTH'(1)) begin
                            state_d = RD_BURST;
                            rem_d   = burstcount - BURST_WIDTH'(1);
                            addr_d  = address + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            WR_BURST: begin
                if (write) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - BURST_WIDTH'(1);
                    if (rem_q == BURST_WIDTH'(1)) state_d = IDLE;
                end
            end
            RD_BURST: begin
                rd_issue = 1'b1;
                addr_d   = addr_q + ADDR_WIDTH'(1);
                rem_d    = rem_q - BURST_WIDTH'(1);
                if (rem_q == BURST_WIDTH'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            waitrequest_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            waitrequest_q <= (state_d == RD_BURST);
        end
    end

    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BEW; b++) begin
                if (byteenable[b]) mem_q[mem_waddr][b*8 +: 8] <= writedata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        sv[0] = rd_issue;
        sd[0] = mem_q[rd_addr];
        for (int i = 1; i < L; i++) begin
            sv[i] = pv_q[i-1];
            sd[i] = pd_q[i-1];
        end
    end

    // Data stages only load on a valid beat, so the last stage holds its value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_q <= '0;
            for (int i = 0; i < L; i++) pd_q[i] <= '0;
        end else begin
            for (int i = 0; i < L; i++) begin
                pv_q[i] <= sv[i];
                if (sv[i]) pd_q[i] <= sd[i];
            end
        end
    end

    assign waitrequest   = waitrequest_q;
    assign readdata      = pd_q[L-1];
    assign readdatavalid = pv_q[L-1];

`ifdef U_MEM_SLAVE_ERR_CNT_EN
    logic        err_inc;
    logic [15:0] err_q;

    assign err_inc = !waitrequest_q &&
                     ((state_q == IDLE && (read || write) && burstcount == '0) ||
                      (state_q == IDLE && read && write) ||
                      (state_q == WR_BURST && read));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (err_inc && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_u_mem_bram_slave.sv
// Scoreboard bench for u_mem_bram_slave: directed bursts, wrap, byte enables,
// back-to-back reads, protocol errors and mid-burst reset.
module tb_u_mem_bram_slave;

    localparam int AW  = 10;
    localparam int DW  = 512;
    localparam int BW  = 7;
    localparam int L   = 2;
    localparam int BEW = DW / 8;
`ifdef U_MEM_SLAVE_ERR_CNT_EN
    localparam int EXP_ERR = 2;
`else
    localparam int EXP_ERR = 0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [AW-1:0]  address;
    logic           read;
    logic           write;
    logic [DW-1:0]  writedata;
    logic [BEW-1:0] byteenable;
    logic [BW-1:0]  burstcount;
    logic           waitrequest;
    logic [DW-1:0]  readdata;
    logic           readdatavalid;
    logic [15:0]    err_count;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    exp_t          expq[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [DW-1:0] last = '0;

    u_mem_bram_slave #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BURST_WIDTH (BW),
        .READ_LATENCY(L)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .burstcount   (burstcount),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last = '0;
            chk("rdv_in_reset", DW'(readdatavalid), DW'(0));
        end else if (readdatavalid) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdv actual=%0h expected=none", readdata);
            end else begin
                e = expq.pop_front();
                chk("rd_data", readdata, e.d);
                chk("rd_cycle", DW'(cyc), DW'(e.c));
                last = e.d;
            end
        end else begin
            chk("rd_hold", readdata, last);
        end
    end

    task automatic drive(input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [BW-1:0] bc, input logic [DW-1:0] d,
                         input logic [BEW-1:0] be, output int c);
        int n;
        write      = w;
        read       = r;
        address    = a;
        burstcount = bc;
        writedata  = d;
        byteenable = be;
        n = 0;
        while (waitrequest && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (waitrequest) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout actual=1 expected=0");
        end
        c = cyc;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic wr_burst(input logic [AW-1:0] a, input int b,
                            input logic [DW-1:0] base, input logic [DW-1:0] step);
        int c;
        logic [DW-1:0] d;
        d = base;
        for (int k = 0; k < b; k++) begin
            drive(1'b1, 1'b0, a, BW'(b), d, '1, c);
            d = d + step;
        end
    endtask

    task automatic rd_burst(input logic [AW-1:0] a, input int b,
                            input logic [DW-1:0] base, input logic [DW-1:0] step);
        int c;
        logic [DW-1:0] d;
        drive(1'b0, 1'b1, a, BW'(b), '0, '1, c);
        d = base;
        for (int k = 0; k < b; k++) begin
            expq.push_back('{d, c + L + k});
            d = d + step;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        int c;
        logic [DW-1:0] ones;
        logic [DW-1:0] be_exp;
        ones   = '1;
        be_exp = ~DW'(8'hFF);
        read = 1'b0;
        write = 1'b0;
        address = '0;
        writedata = '0;
        byteenable = '0;
        burstcount = '0;
        #1 reset = 1'b1;
        idle(3);
        chk("rst_wait", DW'(waitrequest), DW'(1));
        chk("rst_rdv", DW'(readdatavalid), DW'(0));
        chk("rst_rdata", readdata, DW'(0));
        chk("rst_err", DW'(err_count), DW'(0));
        reset = 1'b0;
        chk("rel_wait", DW'(waitrequest), DW'(1));
        idle(1);
        chk("first_edge_wait", DW'(waitrequest), DW'(0));

        wr_burst(10'h010, 4, DW'(8'hA0), DW'(1));
        rd_burst(10'h010, 4, DW'(8'hA0), DW'(1));
        for (int i = 0; i < 4; i++) begin
            chk("burst_wait", DW'(waitrequest), DW'(i < 3));
            idle(1);
        end
        idle(2);

        wr_burst(10'h3FF, 2, DW'(8'h11), DW'(8'h11));
        rd_burst(10'h000, 1, DW'(8'h22), DW'(0));
        rd_burst(10'h3FF, 2, DW'(8'h11), DW'(8'h11));

        wr_burst(10'h005, 1, ones, DW'(0));
        drive(1'b1, 1'b0, 10'h005, BW'(1), '0, BEW'(1), c);
        rd_burst(10'h005, 1, be_exp, DW'(0));

        wr_burst(10'h100, 1, DW'(8'h5A), DW'(0));
        rd_burst(10'h100, 1, DW'(8'h5A), DW'(0));

        wr_burst(10'h020, 3, DW'(8'hB0), DW'(1));
        wr_burst(10'h030, 2, DW'(8'hC0), DW'(1));
        rd_burst(10'h020, 3, DW'(8'hB0), DW'(1));
        rd_burst(10'h030, 2, DW'(8'hC0), DW'(1));
        drain();

        drive(1'b1, 1'b1, 10'h080, BW'(1), DW'(8'h77), '1, c);
        drive(1'b0, 1'b1, 10'h090, BW'(0), '0, '1, c);
        idle(6);
        chk("err_count", DW'(err_count), DW'(EXP_ERR));
        rd_burst(10'h080, 1, DW'(8'h77), DW'(0));
        drain();

        wr_burst(10'h040, 8, DW'(8'h50), DW'(1));
        rd_burst(10'h040, 8, DW'(8'h50), DW'(1));
        idle(4);
        chk("beats_before_reset", DW'(expq.size()), DW'(5));
        reset = 1'b1;
        expq.delete();
        #1;
        chk("mid_rst_wait", DW'(waitrequest), DW'(1));
        chk("mid_rst_rdv", DW'(readdatavalid), DW'(0));
        idle(2);
        chk("mid_rst_wait2", DW'(waitrequest), DW'(1));
        chk("mid_rst_err", DW'(err_count), DW'(0));
        chk("mid_rst_rdata", readdata, DW'(0));
        reset = 1'b0;
        chk("mid_rel_wait", DW'(waitrequest), DW'(1));
        idle(1);
        chk("mid_first_edge_wait", DW'(waitrequest), DW'(0));
        idle(6);
        rd_burst(10'h010, 2, DW'(8'hA0), DW'(1));
        rd_burst(10'h040, 1, DW'(8'h50), DW'(0));
        drain();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
